// File: rtl/gelato_ibuffer.sv
// Per-warp FIFO instruction buffer between decode and issue, with fetch-slot
// reservation tracking for the fetch scheduler and per-warp flush.
module gelato_ibuffer #(
   parameter int unsigned WARP_NUM      = 32,
   parameter int unsigned WARP_ID_WIDTH = 5,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned INST_WIDTH    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     fskd_valid,
   input  logic [WARP_ID_WIDTH-1:0] fskd_warp_id,
   output logic [WARP_NUM-1:0]      buf_avail,
   input  logic                     dec_valid,
   input  logic [WARP_ID_WIDTH-1:0] dec_warp_id,
   input  logic [INST_WIDTH-1:0]    dec_inst,
   output logic                     dec_ready,
   output logic [WARP_NUM-1:0]      iss_valid,
   input  logic [WARP_ID_WIDTH-1:0] iss_warp_id,
   output logic [INST_WIDTH-1:0]    iss_inst,
   input  logic                     iss_pop,
   input  logic                     flush,
   input  logic [WARP_ID_WIDTH-1:0] flush_warp_id
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   SUM_MAX = (CNT_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0]      rd_ptr [WARP_NUM];
   logic [PTR_W-1:0]      wr_ptr [WARP_NUM];
   logic [CNT_W-1:0]      count  [WARP_NUM];
   logic [CNT_W-1:0]      resv   [WARP_NUM];
   logic [INST_WIDTH-1:0] mem    [WARP_NUM][DEPTH];

   logic push_ok, rsv_ok, pop_ok, fl_ok;
   logic [WARP_NUM-1:0] push_vec, rsv_vec, pop_vec, flush_vec;

   always_comb begin
      buf_avail = '0;
      iss_valid = '0;
      for (int unsigned w = 0; w < WARP_NUM; w++) begin
         buf_avail[w] = ({1'b0, count[w]} + {1'b0, resv[w]}) < SUM_MAX;
         iss_valid[w] = count[w] != '0;
      end
   end

   assign dec_ready = count[dec_warp_id] < CNT_MAX;
   assign iss_inst  = mem[iss_warp_id][rd_ptr[iss_warp_id]];

   assign push_ok = rdy && dec_valid && dec_ready;
   assign rsv_ok  = rdy && fskd_valid && buf_avail[fskd_warp_id];
   assign pop_ok  = rdy && iss_pop && iss_valid[iss_warp_id];
   assign fl_ok   = rdy && flush;

   always_comb begin
      push_vec  = '0;
      rsv_vec   = '0;
      pop_vec   = '0;
      flush_vec = '0;
      if (push_ok) push_vec[dec_warp_id]    = 1'b1;
      if (rsv_ok)  rsv_vec[fskd_warp_id]    = 1'b1;
      if (pop_ok)  pop_vec[iss_warp_id]     = 1'b1;
      if (fl_ok)   flush_vec[flush_warp_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned w = 0; w < WARP_NUM; w++) begin
            rd_ptr[w] <= '0;
            wr_ptr[w] <= '0;
            count[w]  <= '0;
            resv[w]   <= '0;
         end
      end else begin
         for (int unsigned w = 0; w < WARP_NUM; w++) begin
            if (flush_vec[w]) begin
               rd_ptr[w] <= '0;
               wr_ptr[w] <= '0;
               count[w]  <= '0;
               resv[w]   <= '0;
            end else begin
               if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PTR_ONE;
               if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PTR_ONE;
               if (push_vec[w] && !pop_vec[w])
                  count[w] <= count[w] + CNT_ONE;
               else if (!push_vec[w] && pop_vec[w])
                  count[w] <= count[w] - CNT_ONE;
               // A same-cycle reservation is consumed by the push it
               // accompanies, which keeps count+resv within DEPTH.
               if (rsv_vec[w] && !push_vec[w])
                  resv[w] <= resv[w] + CNT_ONE;
               else if (push_vec[w] && !rsv_vec[w] && resv[w] != '0)
                  resv[w] <= resv[w] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned w = 0; w < WARP_NUM; w++) begin
         if (push_vec[w] && !flush_vec[w])
            mem[w][wr_ptr[w]] <= dec_inst;
      end
   end

   for (genvar g = 0; g < WARP_NUM; g++) begin : g_inv
      a_slot_bound: assert property (@(posedge clk) disable iff (rst)
         ({1'b0, count[g]} + {1'b0, resv[g]}) <= SUM_MAX);
   end

endmodule

// File: tb/tb_gelato_ibuffer.sv
// Scoreboard bench for gelato_ibuffer: a queue-per-warp reference model
// predicts outputs, a negedge monitor compares them.
module tb_gelato_ibuffer;

   localparam int WN = 32;
   localparam int WW = 5;
   localparam int D  = 2;
   localparam int IW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rdy, fskd_valid, dec_valid, iss_pop, flush;
   logic [WW-1:0] fskd_warp_id, dec_warp_id, iss_warp_id, flush_warp_id;
   logic [IW-1:0] dec_inst;
   logic [WN-1:0] buf_avail, iss_valid;
   logic          dec_ready;
   logic [IW-1:0] iss_inst;

   gelato_ibuffer #(
      .WARP_NUM(WN), .WARP_ID_WIDTH(WW), .DEPTH(D), .INST_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .fskd_valid(fskd_valid), .fskd_warp_id(fskd_warp_id), .buf_avail(buf_avail),
      .dec_valid(dec_valid), .dec_warp_id(dec_warp_id), .dec_inst(dec_inst),
      .dec_ready(dec_ready), .iss_valid(iss_valid), .iss_warp_id(iss_warp_id),
      .iss_inst(iss_inst), .iss_pop(iss_pop), .flush(flush),
      .flush_warp_id(flush_warp_id)
   );

   typedef struct {
      logic [WN-1:0] avail;
      logic [WN-1:0] valid;
      logic          dready;
      bit            head_ok;
      logic [IW-1:0] head;
   } exp_t;

   exp_t          sbq[$];
   exp_t          mon_e;
   logic [IW-1:0] mq[WN][$];
   int            resv_m[WN];
   bit            mvalid = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         chk("buf_avail", IW'(buf_avail), IW'(mon_e.avail));
         chk("iss_valid", IW'(iss_valid), IW'(mon_e.valid));
         chk("dec_ready", IW'(dec_ready), IW'(mon_e.dready));
         if (mon_e.head_ok) chk("iss_inst", iss_inst, mon_e.head);
      end
   end

   // One clock of stimulus: predict pre-edge outputs, then advance the model.
   task automatic cycle();
      exp_t e;
      bit   push_ok, rsv_ok, pop_ok, fl_ok;
      int   pre_resv;
      if (mvalid) begin
         for (int w = 0; w < WN; w++) begin
            e.avail[w] = (mq[w].size() + resv_m[w]) < D;
            e.valid[w] = mq[w].size() != 0;
         end
         e.dready  = mq[dec_warp_id].size() < D;
         e.head_ok = mq[iss_warp_id].size() != 0;
         e.head    = e.head_ok ? mq[iss_warp_id][0] : '0;
         sbq.push_back(e);
      end
      push_ok  = mvalid && rdy && dec_valid && (mq[dec_warp_id].size() < D);
      rsv_ok   = mvalid && rdy && fskd_valid &&
                 ((mq[fskd_warp_id].size() + resv_m[fskd_warp_id]) < D);
      pop_ok   = mvalid && rdy && iss_pop && (mq[iss_warp_id].size() != 0);
      fl_ok    = mvalid && rdy && flush;
      pre_resv = resv_m[dec_warp_id];
      @(posedge clk);
      #1;
      if (rst) begin
         for (int w = 0; w < WN; w++) begin
            mq[w].delete();
            resv_m[w] = 0;
         end
         mvalid = 1'b1;
      end else begin
         if (pop_ok) void'(mq[iss_warp_id].pop_front());
         if (push_ok) mq[dec_warp_id].push_back(dec_inst);
         if (rsv_ok) resv_m[fskd_warp_id]++;
         if (push_ok && (pre_resv > 0 || (rsv_ok && fskd_warp_id == dec_warp_id)))
            resv_m[dec_warp_id]--;
         if (fl_ok) begin
            mq[flush_warp_id].delete();
            resv_m[flush_warp_id] = 0;
         end
      end
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1;
      fskd_valid = 1'b0; dec_valid = 1'b0; iss_pop = 1'b0; flush = 1'b0;
   endtask

   task automatic push(input int w, input logic [IW-1:0] v);
      idle();
      dec_valid = 1'b1; dec_warp_id = WW'(w); dec_inst = v;
      cycle();
   endtask

   task automatic pop(input int w);
      idle();
      iss_pop = 1'b1; iss_warp_id = WW'(w);
      cycle();
   endtask

   function automatic logic [WW-1:0] rand_warp();
      if ($urandom_range(0, 9) < 8) return WW'($urandom_range(0, 3));
      return WW'($urandom_range(0, WN - 1));
   endfunction

   initial begin
      idle();
      fskd_warp_id = '0; dec_warp_id = '0; iss_warp_id = '0; flush_warp_id = '0;
      dec_inst = '0;
      rst = 1'b1;
      cycle();
      cycle();
      idle();
      cycle();

      // warp 3: two reservations, two pushes, two pops
      fskd_valid = 1'b1; fskd_warp_id = 5'd3;
      cycle();
      cycle();
      push(3, 64'hA);
      push(3, 64'hB);
      idle(); iss_warp_id = 5'd3;
      cycle();
      pop(3);
      cycle();
      pop(3);
      idle();
      cycle();

      // warp 5 full: push is held off until the pop frees a slot
      push(5, 64'h50);
      push(5, 64'h51);
      idle();
      dec_valid = 1'b1; dec_warp_id = 5'd5; dec_inst = 64'hC;
      iss_pop = 1'b1; iss_warp_id = 5'd5;
      cycle();
      iss_pop = 1'b0;
      cycle();
      idle();
      cycle();
      pop(5);
      pop(5);
      idle();
      cycle();

      // push+pop on warp 1 with a reserve on warp 2 in the same cycle
      push(1, 64'h10);
      idle();
      dec_valid = 1'b1; dec_warp_id = 5'd1; dec_inst = 64'h11;
      iss_pop = 1'b1; iss_warp_id = 5'd1;
      fskd_valid = 1'b1; fskd_warp_id = 5'd2;
      cycle();
      idle(); iss_warp_id = 5'd1;
      cycle();
      pop(1);

      // flush warp 7 while pushing to it; warp 6 untouched
      push(7, 64'h70);
      push(7, 64'h71);
      push(6, 64'h60);
      idle();
      flush = 1'b1; flush_warp_id = 5'd7;
      dec_valid = 1'b1; dec_warp_id = 5'd7; dec_inst = 64'h72;
      cycle();
      idle(); iss_warp_id = 5'd6;
      cycle();
      iss_warp_id = 5'd7;
      cycle();
      pop(6);

      // wrap-around on warp 0 with a 3-cycle stall in the middle
      push(0, 64'd1);
      for (int k = 2; k <= 5; k++) begin
         if (k == 4) begin
            for (int s = 0; s < 3; s++) begin
               idle();
               rdy = 1'b0;
               dec_valid = 1'b1; dec_warp_id = '0; dec_inst = 64'hDEAD;
               iss_pop = 1'b1; iss_warp_id = '0;
               flush = 1'b1; flush_warp_id = '0;
               cycle();
            end
         end
         idle();
         dec_valid = 1'b1; dec_warp_id = '0; dec_inst = IW'(k);
         iss_pop = 1'b1; iss_warp_id = '0;
         cycle();
      end
      pop(0);
      idle();
      cycle();

      // randomized traffic concentrated on a few warps, with occasional reset
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 999) < 3);
         rdy           = ($urandom_range(0, 9) != 0);
         fskd_valid    = $urandom_range(0, 1) == 1;
         fskd_warp_id  = rand_warp();
         dec_valid     = $urandom_range(0, 9) < 6;
         dec_warp_id   = rand_warp();
         dec_inst      = {$urandom(), $urandom()};
         iss_pop       = $urandom_range(0, 1) == 1;
         iss_warp_id   = rand_warp();
         flush         = $urandom_range(0, 19) == 0;
         flush_warp_id = rand_warp();
         cycle();
      end
      idle();
      cycle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", IW'(sbq.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gelato_ibuffer.md
Name: gelato_ibuffer

Overview:
- Per-warp instruction buffer sitting after the fetch/decode front end.
- Receives decoded instructions and stores up to DEPTH entries per warp in FIFO order.
- Reports per-warp slot availability to the fetch scheduler, which reserves a slot whenever it issues a fetch.
- Presents per-warp head instructions to the issue stage and supports per-warp flush on control-flow change.

Parameters:
WARP_NUM, 32, number of warps (power of two).
WARP_ID_WIDTH, 5, log2(WARP_NUM).
DEPTH, 2, entries per warp FIFO (power of two, at least 2).
INST_WIDTH, 64, decoded instruction payload width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0 all state holds and inputs are ignored
fskd_valid  in  1  fetch scheduler reserves a slot this cycle
fskd_warp_id  in  WARP_ID_WIDTH  warp being fetched
buf_avail  out  WARP_NUM  bit w = (count[w] + resv[w]) < DEPTH
dec_valid  in  1  decoded instruction valid
dec_warp_id  in  WARP_ID_WIDTH  owning warp
dec_inst  in  INST_WIDTH  decoded payload
dec_ready  out  1  count[dec_warp_id] < DEPTH (combinational)
iss_valid  out  WARP_NUM  bit w = count[w] != 0
iss_warp_id  in  WARP_ID_WIDTH  warp selected by issue
iss_inst  out  INST_WIDTH  head entry of iss_warp_id (combinational read)
iss_pop  in  1  consume head of iss_warp_id
flush  in  1  discard all entries and reservations of flush_warp_id
flush_warp_id  in  WARP_ID_WIDTH  warp to flush

Behaviour:
- State per warp:
  - rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH)
  - count (0..DEPTH)
  - resv (0..DEPTH)
  - DEPTH x INST_WIDTH storage
- Reset (rst=1 at posedge): all pointers, counts and resv cleared. Outputs are then buf_avail all ones, iss_valid all zeros, dec_ready 1. iss_inst is don't-care, with a registered-zero storage model allowed. Reset overrides every other input, including mid-operation; no entry survives.
- rdy=0: no state changes; outputs still reflect current state.
- Push:
  - Occurs when dec_valid && dec_ready && rdy.
  - Writes dec_inst at wr_ptr[w], then increments wr_ptr and count.
  - If resv[w] > 0, resv[w] decrements.
  - A push to a warp with resv=0 is legal and stores normally.
- Push when full (dec_ready=0): no effect; the producer holds.
  - dec_ready does not look ahead to a same-cycle pop, so there is no full-buffer bypass.
- Reserve:
  - Occurs when fskd_valid && buf_avail[fskd_warp_id] && rdy; resv[w] increments.
  - Reserve while buf_avail=0: ignored, no state change.
- Pop:
  - Occurs when iss_pop && iss_valid[iss_warp_id] && rdy; increments rd_ptr and decrements count.
  - Pop on an empty warp is ignored.
- Latency: a pushed entry is visible on iss_valid/iss_inst the next cycle.
  - Pop takes effect at the clock edge; the next head appears the following cycle.
- Simultaneous events on the same warp:
  - Push+pop: count unchanged, both pointers advance, and the popped entry is the old head.
  - Reserve+push: resv unchanged (+1, -1) and count +1. buf_avail is evaluated on pre-edge state.
  - Events on different warps are fully independent in the same cycle.
- Flush:
  - Occurs when flush && rdy; sets rd_ptr=wr_ptr=0, count=0, resv=0 for flush_warp_id.
  - Flush wins over push, pop and reserve to the same warp in the same cycle; those events are dropped.
  - Other warps are unaffected.
- Invariant: count[w] + resv[w] <= DEPTH at all times. An SVA assertion is required.
  - A push that would decrement resv while count is already DEPTH cannot occur, because dec_ready gates it.

Test Plan:
- Reset then idle: after rst held 2 cycles -> buf_avail=32'hFFFF_FFFF, iss_valid=0, dec_ready=1.
- Warp 3, DEPTH=2:
  - Reserve twice -> buf_avail[3]=0.
  - Push 0xA then 0xB -> iss_valid[3]=1 and iss_inst=0xA with iss_warp_id=3.
  - Pop -> iss_inst=0xB.
  - Pop -> iss_valid[3]=0 and buf_avail[3]=1.
- Full warp 5 (count=2): push 0xC with dec_valid=1 -> dec_ready=0 and contents unchanged. The same cycle's pop -> count=1; the push is accepted on the next cycle.
- Same-cycle push 0x11 to warp 1, pop warp 1 (head 0x10), reserve warp 2 -> warp1 head=0x11 with count unchanged, resv[2]=1.
- Flush warp 7 holding 2 entries, with push to warp 7 in the same cycle -> count[7]=0, resv[7]=0, iss_valid[7]=0, buf_avail[7]=1; warp 6 contents intact.
- Wrap-around: 5 push/pop pairs on warp 0 with payloads 1..5 -> popped in order 1..5 with pointers wrapping; rdy=0 for 3 cycles mid-sequence -> no state change observed.
